// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
package sync_fifo_pkg;

  localparam int STAT_CNT_W = 16;

  typedef logic [STAT_CNT_W-1:0] stat_cnt_t;

  typedef struct packed {
    logic almost_full;
    logic almost_empty;
  } almost_flags_t;

  // Threshold compares on plain unsigned integers so any pointer width (and
  // later the async variants) can reuse them after zero-extending.
  function automatic almost_flags_t calc_almost_flags(
    input int unsigned depth,
    input int unsigned count,
    input int unsigned af_lvl,
    input int unsigned ae_lvl
  );
    almost_flags_t f;
    f.almost_full  = (depth - count) <= af_lvl;
    f.almost_empty = count <= ae_lvl;
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read, no reset so it can map
// onto distributed RAM.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ring.sv
// Circular-buffer synchronous FIFO with valid/ready on both sides,
// programmable almost-full/almost-empty thresholds and synchronous flush.
// Optional macro SYNC_FIFO_RING_STAT_EN adds o_drop_cnt, a saturating count
// of cycles in which a write was offered but refused.
module sync_fifo_ring
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_flush,
  input  logic                            i_valid_s,
  output logic                            o_ready_s,
  input  logic [DATA_WIDTH-1:0]           i_datain,
  output logic                            o_valid_m,
  input  logic                            i_ready_m,
  output logic [DATA_WIDTH-1:0]           o_dataout,
  input  logic [$clog2(FIFO_DEPTH):0]     i_almostfull_lvl,
  input  logic [$clog2(FIFO_DEPTH):0]     i_almostempty_lvl,
  output logic                            o_almostfull,
  output logic                            o_full,
  output logic                            o_almostempty,
  output logic                            o_empty,
  output logic [$clog2(FIFO_DEPTH):0]     o_count
`ifdef SYNC_FIFO_RING_STAT_EN
  ,
  output stat_cnt_t                       o_drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          push, pop;
  almost_flags_t flags;

  assign o_empty   = (cnt == '0);
  assign o_full    = (cnt == DEPTH_C);
  assign o_count   = cnt;
  // Flush forces both handshakes low, which is what suppresses any
  // coincident push or pop.
  assign o_ready_s = !o_full && !i_flush;
  assign o_valid_m = !o_empty && !i_flush;
  assign push      = i_valid_s && o_ready_s;
  assign pop       = o_valid_m && i_ready_m;

  assign flags = calc_almost_flags(FIFO_DEPTH, 32'(cnt),
                                   32'(i_almostfull_lvl), 32'(i_almostempty_lvl));
  assign o_almostfull  = flags.almost_full;
  assign o_almostempty = flags.almost_empty;

  // Pointer and occupancy update; flush takes priority over everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      cnt <= cnt + CNT_ONE;
      else if (pop && !push) cnt <= cnt - CNT_ONE;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk   (i_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (i_datain),
    .raddr (rd_ptr),
    .rdata (o_dataout)
  );

`ifdef SYNC_FIFO_RING_STAT_EN
  stat_cnt_t drop_cnt;

  // Count refused write offers, saturating; flush and reset clear it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      drop_cnt <= '0;
    else if (i_flush)
      drop_cnt <= '0;
    else if (i_valid_s && !o_ready_s && (drop_cnt != '1))
      drop_cnt <= drop_cnt + stat_cnt_t'(1);
  end

  assign o_drop_cnt = drop_cnt;
`endif

endmodule

// File: doc/sync_fifo_ring.md
Name: sync_fifo_ring

Overview:
Parametrised successor to the team's shift-register sync FIFO. Uses circular-buffer storage with independent read/write pointers, so a pop costs no data movement. Implements a correct valid/ready handshake on both sides, programmable almost-full/almost-empty thresholds, an occupancy count output, and a synchronous flush. Sits between any two same-clock stream stages in the datapath.

Parameters:
DATA_WIDTH, 32, width of each stored word.
FIFO_DEPTH, 16, number of entries; power of two, >= 2.
AW, $clog2(FIFO_DEPTH), localparam pointer width; not overridable.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset; one clock, asynchronous, active-low
i_flush  input  1  synchronous flush; empties the FIFO
i_valid_s  input  1  write request
o_ready_s  output  1  FIFO can accept a word
i_datain  input  DATA_WIDTH  write data
o_valid_m  output  1  o_dataout holds a valid word
i_ready_m  input  1  consumer takes the head word
o_dataout  output  DATA_WIDTH  head-of-FIFO data (first-word-fall-through)
i_almostfull_lvl  input  AW+1  free-entry threshold for o_almostfull
i_almostempty_lvl  input  AW+1  occupancy threshold for o_almostempty
o_almostfull  output  1  free entries <= i_almostfull_lvl
o_full  output  1  count == FIFO_DEPTH
o_almostempty  output  1  count <= i_almostempty_lvl
o_empty  output  1  count == 0
o_count  output  AW+1  current occupancy

Behaviour:
- State: wr_ptr and rd_ptr (AW bits each) and cnt (AW+1 bits), all registered.
- Pointers wrap naturally modulo FIFO_DEPTH.
- Handshake signals:
  - o_ready_s = !o_full && !i_flush.
  - o_valid_m = !o_empty && !i_flush.
  - push = i_valid_s && o_ready_s.
  - pop = o_valid_m && i_ready_m.
- On a push: mem[wr_ptr] <= i_datain; wr_ptr++.
- On a pop: rd_ptr++.
- cnt update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Boundary cases:
  - Full: push is blocked, and a pop in that cycle proceeds alone.
  - Empty: pop is blocked, and a push proceeds alone.
  - No write-through: a word pushed into an empty FIFO appears on o_dataout one cycle later.
- o_dataout = mem[rd_ptr], combinational. It is defined only while o_valid_m = 1; storage is not reset.
- Flags and o_count are combinational from cnt:
  - o_empty = (cnt == 0); o_full = (cnt == FIFO_DEPTH).
  - o_almostfull = (FIFO_DEPTH - cnt) <= i_almostfull_lvl.
  - o_almostempty = cnt <= i_almostempty_lvl.
  - Thresholds are unsigned and may change at any time; flags follow in the same cycle.
- i_flush has highest priority. At the next edge, wr_ptr, rd_ptr and cnt go to 0. Any coincident push or pop is suppressed, because both ready and valid are forced low during the flush.
- Reset (asynchronous, any time, including mid-burst): pointers and cnt go to 0.
  - Resulting outputs: o_empty=1, o_full=0, o_ready_s=1, o_valid_m=0, o_count=0, o_almostempty=1.
  - o_almostfull = (FIFO_DEPTH <= i_almostfull_lvl).
- Latency: push to o_valid_m is 1 cycle. A pop frees a slot (o_ready_s) in the next cycle.

Optional Feature:
Macro: SYNC_FIFO_RING_STAT_EN.
- Defined: adds output o_drop_cnt (16 bits). It increments each cycle in which i_valid_s=1 && o_ready_s=0 && !i_flush. It saturates at 16'hFFFF and clears on reset or i_flush.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - localparam STAT_CNT_W = 16;
  - typedef logic [STAT_CNT_W-1:0] stat_cnt_t;
  - a shared function computing the almost-full/almost-empty comparisons, reused by future async variants.
- One sub-module, sync_fifo_ram, holds the storage:
  - parameters DATA_WIDTH, FIFO_DEPTH;
  - synchronous write port, asynchronous read port;
  - no reset, so it can map to distributed RAM.

Test Plan:
All scenarios use DATA_WIDTH=32, FIFO_DEPTH=16.
1. Reset, then push 0..15 with i_ready_m=0 -> after the 16th edge: o_full=1, o_ready_s=0, o_count=16. A 17th word (0xDEAD) is not accepted.
2. From full, hold i_ready_m=1 -> o_dataout sequence is 0..15, one word per cycle. After the 16th pop: o_empty=1, o_valid_m=0, o_almostempty=1.
3. Preload 5 words, then push and pop every cycle for 40 cycles -> o_count stays 5 and data order is preserved across two pointer wraps.
4. Thresholds: i_almostfull_lvl=2 and i_almostempty_lvl=3 while filling.
   - o_almostempty deasserts when count goes 3->4.
   - o_almostfull asserts at count 14 and stays asserted at 15 and 16.
5. At count 7, assert i_flush together with i_valid_s=1 (0xA5A5A5A5) and i_ready_m=1 -> next cycle o_count=0, o_empty=1. The word is not stored; a subsequent push-then-pop returns only the new data.
6. Assert i_rst_n=0 asynchronously mid-burst at count 9 -> outputs take their reset values immediately. With SYNC_FIFO_RING_STAT_EN, 3 blocked-push cycles while full -> o_drop_cnt=3.
